// File: rtl/router_fifo_if.sv
// Handshake bundle between a router output FIFO and its neighbours.
// Latency: n/a (wiring only).
// Backpressure: full/empty flags carried back to writer and reader.
//
// Ports (signals):
//   sft_rst   : synchronous soft reset from the synchronizer
//   we        : write enable, lfd_state : header-byte flag, data_in : write byte
//   re        : read enable,  data_out  : registered read byte
//   full, empty, pkt_busy : FIFO status
// master = synchronizer/consumer side, slave = FIFO side.
interface router_fifo_if #(
  parameter int WIDTH = 8
);
  logic             sft_rst;
  logic             we;
  logic             lfd_state;
  logic [WIDTH-1:0] data_in;
  logic             re;
  logic [WIDTH-1:0] data_out;
  logic             full;
  logic             empty;
  logic             pkt_busy;

  modport master (
    output sft_rst, we, lfd_state, data_in, re,
    input  data_out, full, empty, pkt_busy
  );

  modport slave (
    input  sft_rst, we, lfd_state, data_in, re,
    output data_out, full, empty, pkt_busy
  );
endinterface

// File: rtl/router_fifo.sv
// Per-port output FIFO of the 1x3 router; stores {header flag, byte}, tracks packet drain.
// Latency: data_out registered, valid one cycle after the accepting read edge.
// Backpressure: writes dropped while full, reads ignored while empty (flags sampled pre-edge).
//
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : router_fifo_if.slave (sft_rst, we, lfd_state, data_in, re,
//         data_out, full, empty, pkt_busy)
module router_fifo #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic         clk,
  input  logic         rst,
  router_fifo_if.slave bus
);

  logic [WIDTH:0]   mem [DEPTH];
  logic [ADDR_W:0]  wr_ptr;
  logic [ADDR_W:0]  rd_ptr;
  logic [6:0]       pkt_cnt;
  logic [6:0]       pkt_next;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH:0]   rd_word;
  logic             empty_w;
  logic             full_w;
  logic             wr_fire;
  logic             rd_fire;

  // Extra wrap bit distinguishes full (wrap bits differ) from empty.
  assign empty_w = (wr_ptr == rd_ptr);
  assign full_w  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                   (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

  assign wr_fire = bus.we & ~full_w;
  assign rd_fire = bus.re & ~empty_w;
  assign rd_word = mem[rd_ptr[ADDR_W-1:0]];

  // Header byte carries payload length in [7:2]; count payload plus parity.
  // A header seen mid-packet simply reloads (truncated packet).
  always_comb begin
    pkt_next = pkt_cnt;
    if (rd_fire) begin
      if (rd_word[WIDTH]) begin
        pkt_next = {1'b0, rd_word[7:2]} + 7'd1;
      end else if (pkt_cnt != 7'd0) begin
        pkt_next = pkt_cnt - 7'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (bus.sft_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_fire) begin
      mem[wr_ptr[ADDR_W-1:0]] <= {bus.lfd_state, bus.data_in};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      pkt_cnt <= '0;
      data_q  <= '0;
    end else if (bus.sft_rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      pkt_cnt <= '0;
      data_q  <= '0;
    end else begin
      if (wr_fire) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_fire) begin
        rd_ptr <= rd_ptr + 1'b1;
        data_q <= rd_word[WIDTH-1:0];
      end
      pkt_cnt <= pkt_next;
    end
  end

  assign bus.data_out = data_q;
  assign bus.full     = full_w;
  assign bus.empty    = empty_w;
  assign bus.pkt_busy = (pkt_cnt != 7'd0);

endmodule
